// File: rtl/argmax_arbiter.sv
// argmax_arbiter: round-robin sharing of one 10-class argmax engine between two score requesters
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req0/1, in_valid0/1,
//   in_data0/1                   requester frame request and score beats
//   grant0/1                     owner may present beats (registered)
//   res_valid0/1, res_class,
//   res_err                      one-cycle result pulse to owner, shared class/error
//   eng_clr, eng_valid, eng_data engine clear and registered score beat path
//   eng_valid_out, eng_decision  engine decision strobe and index
//   busy, frames_done            activity flag, error-free frame count
module argmax_arbiter #(
    parameter int DATA_W  = 18,
    parameter int N_CLASS = 10,
    parameter int TIMEOUT = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0,
    input  logic              req1,
    input  logic              in_valid0,
    input  logic              in_valid1,
    input  logic [DATA_W-1:0] in_data0,
    input  logic [DATA_W-1:0] in_data1,
    output logic              grant0,
    output logic              grant1,
    output logic              res_valid0,
    output logic              res_valid1,
    output logic [3:0]        res_class,
    output logic              res_err,
    output logic              eng_clr,
    output logic              eng_valid,
    output logic [DATA_W-1:0] eng_data,
    input  logic              eng_valid_out,
    input  logic [3:0]        eng_decision,
    output logic              busy,
    output logic [15:0]       frames_done
);
    localparam int CW = $clog2(N_CLASS + 1);
    localparam int TW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {IDLE, CLEAR, LOAD, WAIT, RESP} state_t;

    state_t        state, state_n;
    logic          owner, owner_n, rr, beat, own_req, own_valid, err_n;
    logic [3:0]    cls_n;
    logic [CW-1:0] count;
    logic [TW-1:0] timer;

    assign own_req   = owner ? req1 : req0;
    assign own_valid = owner ? in_valid1 : in_valid0;
    // grant is high exactly while in LOAD, so a beat is an owner valid in LOAD (abort wins)
    assign beat      = state == LOAD && own_req && own_valid;

    always_comb begin
        state_n = state;
        owner_n = owner;
        cls_n   = res_class;
        err_n   = res_err;
        case (state)
            IDLE: if (req0 || req1) begin
                owner_n = (req0 && req1) ? rr : req1;
                state_n = CLEAR;
            end
            CLEAR: state_n = LOAD;
            LOAD: if (!own_req) begin
                state_n = RESP;
                cls_n   = 4'hF;
                err_n   = 1'b1;
            end else if (beat && int'(count) == N_CLASS - 1) begin
                state_n = WAIT;
            end
            WAIT: if (eng_valid_out) begin
                state_n = RESP;
                cls_n   = eng_decision;
                err_n   = int'(eng_decision) >= N_CLASS;
            end else if (int'(timer) == TIMEOUT - 1) begin
                state_n = RESP;
                cls_n   = 4'hF;
                err_n   = 1'b1;
            end
            RESP: state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // every output is registered from the next-state decode so it lines up with the state
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            owner       <= 1'b0;
            rr          <= 1'b0;
            count       <= '0;
            timer       <= '0;
            grant0      <= 1'b0;
            grant1      <= 1'b0;
            res_valid0  <= 1'b0;
            res_valid1  <= 1'b0;
            res_class   <= '0;
            res_err     <= 1'b0;
            eng_clr     <= 1'b1;
            eng_valid   <= 1'b0;
            eng_data    <= '0;
            busy        <= 1'b0;
            frames_done <= '0;
        end else begin
            state      <= state_n;
            owner      <= owner_n;
            count      <= state == CLEAR ? '0 : count + CW'(beat);
            timer      <= state == WAIT ? timer + TW'(1) : '0;
            grant0     <= state_n == LOAD && !owner_n;
            grant1     <= state_n == LOAD && owner_n;
            res_valid0 <= state_n == RESP && !owner_n;
            res_valid1 <= state_n == RESP && owner_n;
            res_class  <= cls_n;
            res_err    <= err_n;
            eng_clr    <= state_n == CLEAR || state_n == RESP;
            eng_valid  <= beat;
            busy       <= state_n != IDLE;
            if (beat)
                eng_data <= owner ? in_data1 : in_data0;
            if (state_n == RESP) begin
                rr <= !owner_n;
                if (!err_n)
                    frames_done <= frames_done + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_argmax_arbiter.sv
// tb_argmax_arbiter: directed bench for argmax_arbiter with a behavioural argmax engine stub
// Ports: none (top-level bench)
module tb_argmax_arbiter;
    localparam int DATA_W = 18;

    logic              clk = 1'b0, rst = 1'b1;
    logic              req0 = 1'b0, req1 = 1'b0, in_valid0 = 1'b0, in_valid1 = 1'b0;
    logic [DATA_W-1:0] in_data0 = '0, in_data1 = '0;
    logic              grant0, grant1, res_valid0, res_valid1, res_err, eng_clr, eng_valid, busy;
    logic [3:0]        res_class;
    logic [DATA_W-1:0] eng_data;
    logic [15:0]       frames_done;
    logic              eng_valid_out;
    logic [3:0]        eng_decision;

    int n_assert = 0, n_fail = 0;
    int n_clr = 0, n_ev = 0, n_wait = 0, n_res = 0;
    int stub_mode = 0;
    int nb, dly;
    logic signed [DATA_W-1:0] best;
    logic [3:0]               best_i;
    logic [DATA_W-1:0]        sc [10];
    int c0, e0, w0, r0;

    always #5 clk = ~clk;

    argmax_arbiter #(.DATA_W(DATA_W), .N_CLASS(10), .TIMEOUT(32)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .req1(req1),
        .in_valid0(in_valid0), .in_valid1(in_valid1),
        .in_data0(in_data0), .in_data1(in_data1),
        .grant0(grant0), .grant1(grant1),
        .res_valid0(res_valid0), .res_valid1(res_valid1),
        .res_class(res_class), .res_err(res_err),
        .eng_clr(eng_clr), .eng_valid(eng_valid), .eng_data(eng_data),
        .eng_valid_out(eng_valid_out), .eng_decision(eng_decision),
        .busy(busy), .frames_done(frames_done)
    );

    // engine stub: signed argmax (first maximum wins), strobes a few cycles after beat 10
    // mode 0 normal, mode 1 never strobes, mode 2 reports decision 12
    always @(posedge clk) begin
        eng_valid_out <= 1'b0;
        if (eng_clr) begin
            nb  <= 0;
            dly <= 0;
        end else begin
            if (eng_valid) begin
                if (nb == 0 || $signed(eng_data) > best) begin
                    best   <= $signed(eng_data);
                    best_i <= 4'(nb);
                end
                nb <= nb + 1;
                if (nb == 9)
                    dly <= 2;
            end
            if (dly > 0) begin
                dly <= dly - 1;
                if (dly == 1 && stub_mode != 1) begin
                    eng_valid_out <= 1'b1;
                    eng_decision  <= stub_mode == 2 ? 4'd12 : best_i;
                end
            end
        end
    end

    // free-running event counters sampled away from the active edge
    always @(negedge clk) begin
        n_clr  <= n_clr + (eng_clr ? 1 : 0);
        n_ev   <= n_ev + (eng_valid ? 1 : 0);
        n_wait <= n_wait + ((busy && !grant0 && !grant1 && !eng_clr) ? 1 : 0);
        n_res  <= n_res + ((res_valid0 || res_valid1) ? 1 : 0);
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input int base, input int idx, input int hi);
        for (int i = 0; i < 10; i++) sc[i] = DATA_W'(base);
        sc[idx] = DATA_W'(hi);
    endtask

    task automatic set_req(input int who, input logic v);
        if (who == 0) req0 = v; else req1 = v;
    endtask

    task automatic wait_grant(input string tag, input int who);
        int t = 0;
        while ((who == 0 ? grant0 : grant1) !== 1'b1 && t < 20) begin
            @(negedge clk);
            t++;
        end
        chk(tag, 32'(t < 20), 32'd1);
    endtask

    task automatic send_beats(input int who, input int n);
        for (int k = 0; k < n; k++) begin
            if (who == 0) begin
                in_valid0 = 1'b1;
                in_data0  = sc[k];
            end else begin
                in_valid1 = 1'b1;
                in_data1  = sc[k];
            end
            @(negedge clk);
        end
        in_valid0 = 1'b0;
        in_valid1 = 1'b0;
    endtask

    task automatic finish(input string tag, input int who, input logic [3:0] cls,
                          input logic err, input logic [15:0] fd);
        int t = 0;
        while ((who == 0 ? res_valid0 : res_valid1) !== 1'b1 && t < 100) begin
            @(negedge clk);
            t++;
        end
        chk({tag, "_seen"}, 32'(t < 100), 32'd1);
        chk({tag, "_class"}, res_class, cls);
        chk({tag, "_err"}, res_err, err);
        chk({tag, "_frames"}, frames_done, fd);
        set_req(who, 1'b0);
        @(negedge clk);
        chk({tag, "_pulse"}, res_valid0 | res_valid1, 0);
    endtask

    task automatic frame(input string tag, input int who, input logic [3:0] cls,
                         input logic err, input logic [15:0] fd);
        set_req(who, 1'b1);
        wait_grant({tag, "_grant"}, who);
        send_beats(who, 10);
        finish(tag, who, cls, err, fd);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_grant0"}, grant0, 0);
        chk({tag, "_grant1"}, grant1, 0);
        chk({tag, "_rv0"}, res_valid0, 0);
        chk({tag, "_rv1"}, res_valid1, 0);
        chk({tag, "_class"}, res_class, 0);
        chk({tag, "_err"}, res_err, 0);
        chk({tag, "_eng_valid"}, eng_valid, 0);
        chk({tag, "_eng_data"}, eng_data, 0);
        chk({tag, "_eng_clr"}, eng_clr, 1);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_frames"}, frames_done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog expired");
    end

    initial begin
        repeat (3) @(negedge clk);
        chk_reset("por");
        rst = 1'b0;
        @(negedge clk);
        chk("clr_fall", eng_clr, 0);

        // single requester, non-owner beats present and must be ignored
        load(10, 7, 500);
        in_valid1 = 1'b1;
        in_data1  = 18'h1FFFF;
        c0 = n_clr;
        e0 = n_ev;
        req0 = 1'b1;
        wait_grant("t1_grant", 0);
        chk("t1_clr_count", n_clr - c0, 1);
        chk("t1_grant1", grant1, 0);
        send_beats(0, 10);
        finish("t1", 0, 4'd7, 1'b0, 16'd1);
        chk("t1_beats", n_ev - e0, 10);
        repeat (3) @(negedge clk);
        chk("t1_hold", res_class, 7);

        // joint requests from reset: requester 0 first, then strict alternation
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        load(-3, 2, 200);
        req0 = 1'b1;
        req1 = 1'b1;
        wait_grant("j0_grant", 0);
        chk("j0_not1", grant1, 0);
        send_beats(0, 10);
        finish("j0", 0, 4'd2, 1'b0, 16'd1);
        load(7, 9, 8);
        wait_grant("j1_grant", 1);
        chk("j1_not0", grant0, 0);
        send_beats(1, 10);
        finish("j1", 1, 4'd9, 1'b0, 16'd2);
        load(-100, 0, -5);
        req0 = 1'b1;
        req1 = 1'b1;
        wait_grant("j2_grant", 0);
        chk("j2_not1", grant1, 0);
        send_beats(0, 10);
        finish("neg", 0, 4'd0, 1'b0, 16'd3);
        req1 = 1'b0;

        // engine never answers: TIMEOUT cycles in WAIT, then error
        stub_mode = 1;
        load(1, 3, 9);
        w0 = n_wait;
        frame("tmo", 0, 4'hF, 1'b1, 16'd3);
        chk("tmo_wait_cycles", n_wait - w0, 32);

        // out-of-range engine decision
        stub_mode = 2;
        frame("dec12", 0, 4'hC, 1'b1, 16'd3);
        stub_mode = 0;

        // requester 1 drops after 4 beats, then a clean extreme-value frame
        load(0, 1, 5);
        req1 = 1'b1;
        wait_grant("ab_grant", 1);
        send_beats(1, 4);
        req1 = 1'b0;
        finish("abort", 1, 4'hF, 1'b1, 16'd3);
        load(-131072, 4, 131071);
        frame("after_ab", 1, 4'd4, 1'b0, 16'd4);

        // one-cycle reset while beat 5 is presented
        load(10, 7, 500);
        r0 = n_res;
        req0 = 1'b1;
        wait_grant("rst_grant", 0);
        send_beats(0, 5);
        in_valid0 = 1'b1;
        in_data0  = sc[5];
        rst = 1'b1;
        @(negedge clk);
        chk_reset("mid_rst");
        rst = 1'b0;
        in_valid0 = 1'b0;
        req0 = 1'b0;
        repeat (10) @(negedge clk);
        chk("rst_no_pulse", n_res - r0, 0);
        frame("post_rst", 0, 4'd7, 1'b0, 16'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
